// File: rtl/beep_pkg.sv
// Shared constants for the buzzer path: FSM state encoding, note periods at 100 MHz
// and default timing for the beep arbiter.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } beep_state_t;

    localparam int unsigned TICK_CYCLES_125MS = 12_500_000;
    localparam int unsigned GAP_CYCLES_12MS5  = 1_250_000;

    // Tone periods in 100 MHz clock cycles (clk / note frequency)
    localparam int unsigned C4   = 382_219;
    localparam int unsigned D4   = 340_530;
    localparam int unsigned E4   = 303_370;
    localparam int unsigned F4   = 286_345;
    localparam int unsigned FS_4 = 270_277;
    localparam int unsigned G4   = 255_102;
    localparam int unsigned A4   = 227_273;
    localparam int unsigned B4   = 202_478;
    localparam int unsigned C5   = 191_113;
    localparam int unsigned D5   = 170_262;
    localparam int unsigned REST = 0;

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave generator: counts 0..period-1 while enabled, low half first.
// Periods 0 and 1 produce a silent output.
module beep_tone_gen
    import beep_pkg::*;
#(
    parameter int unsigned PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    output logic                beep
);

    logic [PERIOD_W-1:0] r_tone_cnt;
    logic                r_beep;
    logic [PERIOD_W-1:0] w_half;
    logic                w_wrap;
    logic                w_audible;

    assign w_half    = period >> 1;
    assign w_wrap    = (period == '0) || (r_tone_cnt >= period - PERIOD_W'(1));
    assign w_audible = (period > PERIOD_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tone_cnt <= '0;
            r_beep     <= 1'b0;
        end else if (!en) begin
            r_tone_cnt <= '0;
            r_beep     <= 1'b0;
        end else begin
            r_beep     <= w_audible && (r_tone_cnt >= w_half);
            r_tone_cnt <= w_wrap ? '0 : r_tone_cnt + PERIOD_W'(1);
        end
    end

    assign beep = r_beep;

endmodule

// File: rtl/beep_arbiter.sv
// Fixed-priority buzzer arbiter: grants one note at a time, times its duration and
// the trailing gap, supports preemption by higher-priority sources and a global mute.
module beep_arbiter
    import beep_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned PERIOD_W    = 20,
    parameter int unsigned DUR_W       = 6,
    parameter int unsigned TICK_CYCLES = TICK_CYCLES_125MS,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_12MS5,
    parameter int unsigned PREEMPT     = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sound_en,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*PERIOD_W-1:0] period,
    input  logic [NUM_REQ*DUR_W-1:0]    dur,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          abort,
    output logic                        busy,
    output logic                        beep
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    beep_state_t         r_state;
    beep_state_t         w_state_next;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_abort;
    logic [IDX_W-1:0]    r_idx;
    logic [PERIOD_W-1:0] r_period;
    logic [DUR_W-1:0]    r_dur;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;

    logic [IDX_W-1:0]    w_win;
    logic                w_req_any;
    logic                w_hp_any;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [PERIOD_W-1:0] w_period_sel;
    logic [DUR_W-1:0]    w_dur_sel;
    logic [DUR_W-1:0]    w_dur_last;
    logic                w_last;
    logic                w_load;
    logic                w_done_set;
    logic                w_abort_set;
    logic                w_tone_en;
    logic                w_beep;

    // Lowest set request index wins; it also serves as the preemption candidate.
    always_comb begin
        w_win     = '0;
        w_req_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !w_req_any) begin
                w_win     = IDX_W'(i);
                w_req_any = 1'b1;
            end
        end
    end

    assign w_hp_any     = w_req_any && (w_win < r_idx);
    assign w_win_onehot = NUM_REQ'(1) << w_win;

    always_comb begin
        w_period_sel = '0;
        w_dur_sel    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_period_sel = period[i*PERIOD_W +: PERIOD_W];
                w_dur_sel    = dur[i*DUR_W +: DUR_W];
            end
        end
    end

    assign w_dur_last = (r_dur == '0) ? '0 : r_dur - DUR_W'(1);
    assign w_last     = (r_tick_cnt == TICK_LAST) && (r_dur_cnt == w_dur_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Mute dominates; within PLAY, completion takes precedence over preemption.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done_set   = 1'b0;
        w_abort_set  = 1'b0;
        if (!sound_en) begin
            w_state_next = ST_IDLE;
            w_abort_set  = (r_state == ST_PLAY);
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        w_state_next = ST_PLAY;
                        w_load       = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (w_last) begin
                        w_done_set   = 1'b1;
                        w_state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else if ((PREEMPT != 0) && w_hp_any) begin
                        w_abort_set = 1'b1;
                        w_load      = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_done     <= '0;
            r_abort    <= '0;
            r_idx      <= '0;
            r_period   <= '0;
            r_dur      <= '0;
            r_tick_cnt <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            // r_grant is the owner's one-hot throughout PLAY, so it addresses the pulse.
            r_done  <= w_done_set ? r_grant : '0;
            r_abort <= w_abort_set ? r_grant : '0;

            if (w_load) begin
                r_grant    <= w_win_onehot;
                r_idx      <= w_win;
                r_period   <= w_period_sel;
                r_dur      <= w_dur_sel;
                r_tick_cnt <= '0;
                r_dur_cnt  <= '0;
            end else if (w_state_next != ST_PLAY) begin
                r_grant    <= '0;
                r_tick_cnt <= '0;
                r_dur_cnt  <= '0;
            end else if (r_tick_cnt == TICK_LAST) begin
                r_tick_cnt <= '0;
                r_dur_cnt  <= r_dur_cnt + DUR_W'(1);
            end else begin
                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end

            if ((r_state == ST_GAP) && (w_state_next == ST_GAP)) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    // Tone runs only while the same note continues; a new or ended note restarts it silent.
    assign w_tone_en = (r_state == ST_PLAY) && (w_state_next == ST_PLAY) && !w_load;

    beep_tone_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .en     (w_tone_en),
        .period (r_period),
        .beep   (w_beep)
    );

    assign grant = r_grant;
    assign done  = r_done;
    assign abort = r_abort;
    assign busy  = (r_state != ST_IDLE);
    assign beep  = w_beep;

endmodule

// File: tb/tb_beep_arbiter.sv
// Directed bench for beep_arbiter with short tick/gap timing; a second instance
// runs without preemption for the wait-until-idle case.
module tb_beep_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned PERIOD_W = 20;
    localparam int unsigned DUR_W    = 6;

    logic                        clk      = 1'b0;
    logic                        rst      = 1'b1;
    logic                        sound_en = 1'b1;
    logic [NUM_REQ-1:0]          req      = '0;
    logic [NUM_REQ*PERIOD_W-1:0] period   = '0;
    logic [NUM_REQ*DUR_W-1:0]    dur      = '0;
    logic [NUM_REQ-1:0]          grant, done, abort;
    logic                        busy, beep;
    logic [NUM_REQ-1:0]          np_grant, np_done, np_abort;
    logic                        np_busy, np_beep;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    beep_arbiter #(
        .NUM_REQ(NUM_REQ), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W),
        .TICK_CYCLES(10), .GAP_CYCLES(3), .PREEMPT(1)
    ) dut (
        .clk(clk), .rst(rst), .sound_en(sound_en), .req(req), .period(period), .dur(dur),
        .grant(grant), .done(done), .abort(abort), .busy(busy), .beep(beep)
    );

    beep_arbiter #(
        .NUM_REQ(NUM_REQ), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W),
        .TICK_CYCLES(10), .GAP_CYCLES(3), .PREEMPT(0)
    ) dut_np (
        .clk(clk), .rst(rst), .sound_en(sound_en), .req(req), .period(period), .dur(dur),
        .grant(np_grant), .done(np_done), .abort(np_abort), .busy(np_busy), .beep(np_beep)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_note(input int i, input int p, input int d);
        period[i*PERIOD_W +: PERIOD_W] = PERIOD_W'(p);
        dur[i*DUR_W +: DUR_W]          = DUR_W'(d);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        sound_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        step(2);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", grant); end
        tests++; if (done !== 4'b0000) begin fails++; $display("FAIL reset_done: got %b want 0000", done); end
        tests++; if (abort !== 4'b0000) begin fails++; $display("FAIL reset_abort: got %b want 0000", abort); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL reset_beep: got %b want 0", beep); end
    endtask

    task automatic test_single_note();
        logic exp_b;
        do_reset();
        set_note(2, 8, 2);
        req = 4'b0100;
        step(1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
        req = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            exp_b = (k == 0) ? 1'b0 : (((k - 1) % 8) >= 4);
            tests++; if (grant !== 4'b0100) begin fails++; $display("FAIL single_grant c%0d: got %b want 0100", k, grant); end
            tests++; if (beep !== exp_b) begin fails++; $display("FAIL single_beep c%0d: got %b want %b", k, beep, exp_b); end
            tests++; if (done !== 4'b0000) begin fails++; $display("FAIL single_early_done c%0d: got %b want 0000", k, done); end
            step(1);
        end
        tests++; if (done !== 4'b0100) begin fails++; $display("FAIL single_done: got %b want 0100", done); end
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_grant_drop: got %b want 0000", grant); end
        for (int g = 0; g < 3; g++) begin
            tests++; if (beep !== 1'b0) begin fails++; $display("FAIL gap_beep g%0d: got %b want 0", g, beep); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL gap_busy g%0d: got %b want 1", g, busy); end
            step(1);
            tests++; if (done !== 4'b0000) begin fails++; $display("FAIL gap_done_pulse g%0d: got %b want 0000", g, done); end
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_note(1, 4, 1);
        set_note(3, 4, 1);
        req = 4'b1010;
        step(1);
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL simul_first: got %b want 0010", grant); end
        step(10);
        tests++; if (done !== 4'b0010) begin fails++; $display("FAIL simul_done1: got %b want 0010", done); end
        req = 4'b1000;
        step(3);
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL simul_wait_gap: got %b want 0000", grant); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL simul_idle_busy: got %b want 0", busy); end
        step(1);
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL simul_second: got %b want 1000", grant); end
        step(10);
        tests++; if (done !== 4'b1000) begin fails++; $display("FAIL simul_done3: got %b want 1000", done); end
        req = 4'b0000;
    endtask

    task automatic test_preempt();
        logic exp_b;
        do_reset();
        set_note(3, 6, 5);
        set_note(0, 4, 1);
        req = 4'b1000;
        step(1);
        tests++; if (grant !== 4'b1000) begin fails++; $display("FAIL pre_grant3: got %b want 1000", grant); end
        for (int k = 0; k < 12; k++) begin
            tests++; if (abort !== 4'b0000) begin fails++; $display("FAIL pre_early_abort c%0d: got %b want 0000", k, abort); end
            step(1);
        end
        req = 4'b1001;
        step(1);
        tests++; if (abort !== 4'b1000) begin fails++; $display("FAIL pre_abort: got %b want 1000", abort); end
        tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL pre_grant0: got %b want 0001", grant); end
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL pre_beep_restart: got %b want 0", beep); end
        req = 4'b0001;
        for (int k = 1; k < 10; k++) begin
            step(1);
            exp_b = (((k - 1) % 4) >= 2);
            tests++; if (beep !== exp_b) begin fails++; $display("FAIL pre_beep c%0d: got %b want %b", k, beep, exp_b); end
            tests++; if (abort !== 4'b0000) begin fails++; $display("FAIL pre_abort_len c%0d: got %b want 0000", k, abort); end
            tests++; if (done !== 4'b0000) begin fails++; $display("FAIL pre_no_done c%0d: got %b want 0000", k, done); end
            tests++; if (grant !== 4'b0001) begin fails++; $display("FAIL pre_hold c%0d: got %b want 0001", k, grant); end
        end
        step(1);
        tests++; if (done !== 4'b0001) begin fails++; $display("FAIL pre_done0: got %b want 0001", done); end
        req = 4'b0000;
    endtask

    task automatic test_no_preempt();
        do_reset();
        set_note(3, 6, 5);
        set_note(0, 4, 1);
        req = 4'b1000;
        step(1);
        tests++; if (np_grant !== 4'b1000) begin fails++; $display("FAIL np_grant3: got %b want 1000", np_grant); end
        step(12);
        req = 4'b1001;
        for (int k = 12; k < 50; k++) begin
            tests++; if (np_grant !== 4'b1000) begin fails++; $display("FAIL np_hold c%0d: got %b want 1000", k, np_grant); end
            tests++; if (np_abort !== 4'b0000) begin fails++; $display("FAIL np_abort c%0d: got %b want 0000", k, np_abort); end
            tests++; if (np_done !== 4'b0000) begin fails++; $display("FAIL np_early_done c%0d: got %b want 0000", k, np_done); end
            step(1);
        end
        tests++; if (np_done !== 4'b1000) begin fails++; $display("FAIL np_done3: got %b want 1000", np_done); end
        req = 4'b0001;
        step(3);
        tests++; if (np_grant !== 4'b0000) begin fails++; $display("FAIL np_gap_wait: got %b want 0000", np_grant); end
        step(1);
        tests++; if (np_grant !== 4'b0001) begin fails++; $display("FAIL np_grant0: got %b want 0001", np_grant); end
        step(10);
        tests++; if (np_done !== 4'b0001) begin fails++; $display("FAIL np_done0: got %b want 0001", np_done); end
        req = 4'b0000;
    endtask

    task automatic test_rest_zero_dur();
        for (int p = 0; p < 2; p++) begin
            do_reset();
            set_note(1, p, 0);
            req = 4'b0010;
            step(1);
            tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL rest_grant p%0d: got %b want 0010", p, grant); end
            for (int k = 0; k < 10; k++) begin
                tests++; if (beep !== 1'b0) begin fails++; $display("FAIL rest_beep p%0d c%0d: got %b want 0", p, k, beep); end
                tests++; if (done !== 4'b0000) begin fails++; $display("FAIL rest_early_done p%0d c%0d: got %b want 0000", p, k, done); end
                step(1);
            end
            tests++; if (done !== 4'b0010) begin fails++; $display("FAIL rest_done p%0d: got %b want 0010", p, done); end
            req = 4'b0000;
        end
    endtask

    task automatic test_mute_and_reset();
        do_reset();
        set_note(2, 4, 2);
        req = 4'b0100;
        step(6);
        sound_en = 1'b0;
        step(1);
        tests++; if (abort !== 4'b0100) begin fails++; $display("FAIL mute_abort: got %b want 0100", abort); end
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL mute_grant: got %b want 0000", grant); end
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL mute_beep: got %b want 0", beep); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mute_busy: got %b want 0", busy); end
        tests++; if (done !== 4'b0000) begin fails++; $display("FAIL mute_done: got %b want 0000", done); end
        set_note(1, 4, 2);
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step(1);
            tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL mute_no_grant c%0d: got %b want 0000", k, grant); end
            tests++; if (abort !== 4'b0000) begin fails++; $display("FAIL mute_abort_len c%0d: got %b want 0000", k, abort); end
        end
        sound_en = 1'b1;
        step(1);
        tests++; if (grant !== 4'b0010) begin fails++; $display("FAIL unmute_grant: got %b want 0010", grant); end
        step(3);
        tests++; if (beep !== 1'b1) begin fails++; $display("FAIL prereset_beep: got %b want 1", beep); end
        rst = 1'b1;
        #1;
        tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL rst_grant: got %b want 0000", grant); end
        tests++; if (beep !== 1'b0) begin fails++; $display("FAIL rst_beep: got %b want 0", beep); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++; if ({done, abort} !== 8'h00) begin fails++; $display("FAIL rst_pulses: got %b want 00000000", {done, abort}); end
        req = 4'b0000;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_simultaneous();
        test_preempt();
        test_no_preempt();
        test_rest_zero_dur();
        test_mute_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/beep_arbiter.md
Name: beep_arbiter

Overview:
Shares the single board buzzer between NUM_REQ sound sources (game-over melody, jump effect, score effect, menu click). Each source plays one note per grant. The block grants requests by fixed priority, latches the note's period and duration, and generates the square wave itself. It handles optional preemption, an inter-note gap, and a global mute. It sits between the per-mode melody sequencers and the top-level beep pin.

Parameters:
NUM_REQ, 4, number of requesters; index 0 is highest priority
PERIOD_W, 20, width of tone period in clk cycles
DUR_W, 6, width of note duration in ticks
TICK_CYCLES, 12500000, clk cycles per tick (125 ms at 100 MHz)
GAP_CYCLES, 1250000, silent cycles after each completed note (12.5 ms)
PREEMPT, 1, 1 = a higher-priority request aborts the note in progress

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
sound_en  input  1  0 = mute and flush; 1 = normal operation
req  input  NUM_REQ  level request per source; held until done/abort
period  input  NUM_REQ*PERIOD_W  packed tone periods; slice i belongs to source i; 0 = rest
dur  input  NUM_REQ*DUR_W  packed durations in ticks; slice i belongs to source i
grant  output  NUM_REQ  one-hot (or zero) current owner, registered
done  output  NUM_REQ  1-cycle pulse to source i when its note completes
abort  output  NUM_REQ  1-cycle pulse to source i when its note is preempted or flushed
busy  output  1  high in PLAY or GAP
beep  output  1  buzzer drive, registered

Behaviour:
- Reset: state=IDLE, grant=0, done=0, abort=0, busy=0, beep=0, all counters 0.
- States: IDLE, PLAY, GAP.
- IDLE: if sound_en and req!=0, take win = lowest set index. Next cycle: state=PLAY, grant=onehot(win), latch period[win] and dur[win], tick_cnt=0, dur_cnt=0, tone_cnt=0. Grant latency is 1 cycle after req is seen.
- Latched dur=0 is treated as 1.
- PLAY lasts exactly max(dur,1)*TICK_CYCLES cycles.
- On the last PLAY cycle: next cycle done[win]=1 for one cycle, grant=0, state=GAP.
- GAP lasts exactly GAP_CYCLES cycles with beep=0, then state=IDLE.
- If GAP_CYCLES=0, go straight from PLAY to IDLE.
- New requests wait during GAP. A source may re-request in the cycle done is seen.
- Tone generator (active in PLAY): tone_cnt counts 0..P-1 and wraps, where P is the latched period.
  - beep <= (tone_cnt >= P>>1): 50% duty, low half first.
  - P=0 (rest) and P=1 give beep=0 for the whole note.
  - beep=0 in IDLE and GAP.
- Inputs are not re-sampled during a note; changing period, dur or req during PLAY has no effect.
- Deasserting req during PLAY does not cancel the note.
- Preemption (PREEMPT=1): in PLAY, if some req[j] is set with j < current index, next cycle:
  - abort[cur]=1 for one cycle;
  - grant=onehot(lowest such j), with period and dur re-latched and all counters cleared;
  - no gap is inserted.
- Preemption (PREEMPT=0): higher-priority requests wait until IDLE.
- PLAY completion and a preemption condition in the same cycle: completion wins (done, then GAP).
- sound_en=0 (synchronous flush, any state):
  - next cycle state=IDLE, grant=0, beep=0;
  - abort pulse to the owner if the flush happens in PLAY;
  - no done pulse.
  - While sound_en=0, no grants are issued.
- Only one of done/abort can be high at any cycle, and at most one bit of it.
- Counter widths: tick_cnt sized for TICK_CYCLES-1, dur_cnt DUR_W bits, tone_cnt PERIOD_W bits; no overflow is possible.

Decomposition:
- Shared package beep_pkg: note-period constants (C4, D4, E4, F4, G4, A4, B4, C5, D5, FS_4, REST=0) and TICK_CYCLES_125MS.
- One sub-module, beep_tone_gen. Inputs clk, rst, en, period; output beep; holds the tone_cnt and duty compare.
- The arbiter FSM, priority encoder and duration counters stay in beep_arbiter.

Test Plan:
Simulate with TICK_CYCLES=10, GAP_CYCLES=3, NUM_REQ=4.
- Single note: req[2]=1, period[2]=8, dur[2]=2 -> grant=0100 one cycle later; 20 PLAY cycles with beep repeating 0000_1111; done[2] pulse; beep=0 for 3 cycles; busy drops.
- Simultaneous requests: req=1010 -> grant=0010 first; after its done and the gap, grant=1000.
- Preemption: source 3 playing dur=5, req[0] raised at PLAY cycle 12 -> abort[3] pulse; next cycle grant=0001 with counters restarted; no done[3].
- PREEMPT=0 rerun of the preemption case -> source 3 completes all 50 cycles with done[3]; source 0 is granted after the gap.
- Rest and zero duration: period=0, dur=0 -> beep stays 0 for 10 cycles, then done.
- Mute/reset mid-note: sound_en=0 at PLAY cycle 5 -> abort pulse, grant=0, beep=0 the next cycle. Asserting rst mid-note -> immediate all-zero outputs.
